regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Sequencer and arbiter for the single write port of the 4-entry × 32-bit `RegFile`. After reset it clears every register by writing zero. It then shares the write port between two requesters, for example the ALU writeback and the load unit, using a valid/ready handshake and round-robin priority. It drives `RegWrite`, `WriteReg` and `WriteData` of `RegFile` directly from registers.

## Interface
- `DATA_W`, 32, data width; matches `RegFile` `WriteData`.
- `ADDR_W`, 2, register address width.
- `NREG`, 4, number of registers (= 2**`ADDR_W`).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_addr`  in  `ADDR_W`  requester 0 target register.
- `req0_data`  in  `DATA_W`  requester 0 write data.
- `req0_ready`  out  1  requester 0 transfer accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`  same as above, for requester 1.
- `RegWrite`  out  1  write enable to `RegFile`.
- `WriteReg`  out  `ADDR_W`  write address to `RegFile`.
- `WriteData`  out  `DATA_W`  write data to `RegFile`.
- `grant_id`  out  1  requester whose write is currently on the port; 0 during INIT.
- `init_done`  out  1  clear sequence complete; arbiter live.

## Operation
- **States:** INIT, RUN.
- **Reset:** state = INIT, init counter = 0, priority pointer = 0.
- **INIT:** one write per cycle. Each cycle the output registers load `RegWrite=1`, `WriteReg=cnt`, `WriteData=0`, `grant_id=0`, then `cnt` increments.
  - When `cnt == NREG-1` is loaded, state goes to RUN and `init_done` goes to 1 on the same edge.
  - Both `reqN_ready` are 0 throughout INIT.
- **RUN:** `reqN_ready` is combinational from the valids, the pointer and the state. At most one ready is high per cycle.
  - Only one valid high: that requester gets ready.
  - Both valid: the requester equal to the pointer gets ready.
  - Neither valid: both readies are 0.
- **Transfer:** occurs when `reqN_valid && reqN_ready`. At the next edge:
  - outputs load `RegWrite=1`, `WriteReg=reqN_addr`, `WriteData=reqN_data`, `grant_id=N`;
  - the pointer moves to the other requester (1-N).
- **No transfer in RUN:** next edge `RegWrite=0`. `WriteReg`, `WriteData` and `grant_id` hold their previous values. The pointer is unchanged.
- **Requester rules:** once `valid` is raised, `valid`, `addr` and `data` stay stable until ready. Ready never depends on the ready of the same cycle.
- **Same-address requests:** no merging. Both writes are issued in grant order, so the later grant wins in `RegFile`.
- **Reset mid-operation:** a pending or registered write is dropped, outputs return to reset values, and INIT restarts from address 0.
- `init_done` stays 1 until the next reset.

## Timing
- **Reset values:** `RegWrite=0`, `WriteReg=0`, `WriteData=0`, `grant_id=0`, `init_done=0`, `req0_ready=0`, `req1_ready=0`.
- **INIT length:**
  - first edge with `reset=0`: outputs hold `WriteReg=0`, `RegWrite=1`;
  - edges 1..`NREG`: addresses 0..`NREG-1`;
  - `init_done=1` after edge `NREG`;
  - readies may assert in the cycle after edge `NREG`.
- **Latency:** a handshake in cycle t puts the write on the port during cycle t+1, and `RegFile` captures it at the end of t+1. A read of that address reflects the new value from cycle t+2.
- **Throughput:** one write per cycle sustained. With both requesters continuously valid, grants strictly alternate 0,1,0,1…
- **Starvation bound:** a valid requester is granted within 2 cycles in RUN.

## Test plan
- **Clear sequence:** hold `reset=1` for 2 cycles, then release.
  - `RegWrite=1` for exactly 4 cycles with `WriteReg` 0,1,2,3 and `WriteData=0`; then `init_done=1`.
  - Registers 0–3 read `32'h00000000`.
- **Single requester:** `req0` writes `32'hAAAAFFFF` to register 2.
  - `req0_ready=1` in the same cycle.
  - Next cycle `RegWrite=1`, `WriteReg=2`, `grant_id=0`.
  - `ReadData1` for register 2 shows `32'hAAAAFFFF` two cycles after the handshake.
- **Contention:** both valid continuously from the first RUN cycle; `req0` targets register 1 with `32'h11111111`, `req1` targets register 3 with `32'h33333333`.
  - Grants go 0,1,0,1 (pointer starts at 0).
  - Each requester is served every 2 cycles; `grant_id` alternates.
- **Same address:** `req0` writes `32'h1` and `req1` writes `32'h2`, both to register 0, both valid together, pointer = 1.
  - `req1` is granted first, then `req0`.
  - Register 0 ends at `32'h1`.
- **Idle:** no valids for 3 cycles after a write.
  - `RegWrite=0`; `WriteReg` and `WriteData` hold their last values; the pointer is unchanged.
- **Reset mid-operation:** assert `reset` in the cycle of a `req1` handshake.
  - That write never reaches `RegFile` (`RegWrite=0` next cycle).
  - INIT reruns from address 0 and `init_done` returns to 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 4x32 RegFile: clears every entry after reset, then
// round-robin arbitrates two valid/ready requesters onto the registered write port.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              grant_id,
    output logic              init_done
);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              gid;
    } wrPort_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] initCnt, initCntNext;
    logic              ptr, ptrNext;
    logic              doneReg, doneNext;
    wrPort_t           port, portNext;

    // Ready looks only at valids, pointer and state, never at the other ready.
    assign req0_ready = (state == RUN) && req0_valid && (!req1_valid || !ptr);
    assign req1_ready = (state == RUN) && req1_valid && (!req0_valid ||  ptr);

    always_comb begin
        stateNext   = state;
        initCntNext = initCnt;
        ptrNext     = ptr;
        doneNext    = doneReg;
        portNext    = port;
        portNext.we = 1'b0;
        case (state)
            INIT: begin
                portNext    = '{we: 1'b1, addr: initCnt, data: '0, gid: 1'b0};
                initCntNext = initCnt + 1'b1;
                if (initCnt == ADDR_W'(NREG - 1)) begin
                    stateNext = RUN;
                    doneNext  = 1'b1;
                end
            end
            RUN: begin
                if (req0_ready) begin
                    portNext = '{we: 1'b1, addr: req0_addr, data: req0_data, gid: 1'b0};
                    ptrNext  = 1'b1;
                end else if (req1_ready) begin
                    portNext = '{we: 1'b1, addr: req1_addr, data: req1_data, gid: 1'b1};
                    ptrNext  = 1'b0;
                end
            end
            default: stateNext = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            initCnt <= '0;
            ptr     <= 1'b0;
            doneReg <= 1'b0;
            port    <= '0;
        end else begin
            state   <= stateNext;
            initCnt <= initCntNext;
            ptr     <= ptrNext;
            doneReg <= doneNext;
            port    <= portNext;
        end
    end

    assign RegWrite  = port.we;
    assign WriteReg  = port.addr;
    assign WriteData = port.data;
    assign grant_id  = port.gid;
    assign init_done = doneReg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed steps plus random traffic against a
// transaction-level model of the clear sequence, round-robin grants and RegFile contents.
module tb_regfile_write_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int NREG   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
    logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
    logic              req0_ready, req1_ready;
    logic              RegWrite, grant_id, init_done;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .grant_id(grant_id), .init_done(init_done)
    );

    // RegFile stand-in, written straight from the arbiter's port.
    logic [DATA_W-1:0] rf [NREG];
    always @(posedge clk) if (RegWrite) rf[WriteReg] <= WriteData;

    // Reference model
    bit                mRun = 0;
    int                mCnt = 0;
    int                mPtr = 0;
    bit                eWe = 0, eGid = 0, eDone = 0;
    logic [ADDR_W-1:0] eAddr = '0;
    logic [DATA_W-1:0] eData = '0;
    logic [DATA_W-1:0] mm [NREG];
    bit                h0 = 0, h1 = 0;
    int                checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check readies for the inputs already applied, advance model, check outputs.
    task automatic cycle();
        bit r0, r1;
        #1;
        r0 = mRun && req0_valid && (!req1_valid || mPtr == 0);
        r1 = mRun && req1_valid && (!req0_valid || mPtr == 1);
        chk("req0_ready", {127'b0, req0_ready}, {127'b0, r0});
        chk("req1_ready", {127'b0, req1_ready}, {127'b0, r1});
        h0 = r0;
        h1 = r1;
        @(posedge clk);
        if (eWe) mm[eAddr] = eData;
        if (reset) begin
            mRun = 0; mCnt = 0; mPtr = 0;
            eWe = 0; eAddr = '0; eData = '0; eGid = 0; eDone = 0;
        end else if (!mRun) begin
            eWe = 1; eAddr = ADDR_W'(mCnt); eData = '0; eGid = 0;
            if (mCnt == NREG - 1) begin mRun = 1; eDone = 1; end
            mCnt++;
        end else if (r0) begin
            eWe = 1; eAddr = req0_addr; eData = req0_data; eGid = 0; mPtr = 1;
        end else if (r1) begin
            eWe = 1; eAddr = req1_addr; eData = req1_data; eGid = 1; mPtr = 0;
        end else begin
            eWe = 0;
        end
        @(negedge clk);
        chk("RegWrite",  {127'b0, RegWrite},  {127'b0, eWe});
        chk("WriteReg",  {126'b0, WriteReg},  {126'b0, eAddr});
        chk("WriteData", {96'b0, WriteData},  {96'b0, eData});
        chk("grant_id",  {127'b0, grant_id},  {127'b0, eGid});
        chk("init_done", {127'b0, init_done}, {127'b0, eDone});
        if (eDone) chk("regfile", {rf[3], rf[2], rf[1], rf[0]}, {mm[3], mm[2], mm[1], mm[0]});
    endtask

    initial begin
        // Clear sequence
        reset = 1; cycle(); cycle();
        reset = 0;
        for (int i = 0; i < NREG; i++) begin
            cycle();
            chk("init_addr", {126'b0, WriteReg}, 128'(i));
        end
        chk("init_done_after_clear", {127'b0, init_done}, 128'd1);
        cycle();
        chk("cleared", {rf[3], rf[2], rf[1], rf[0]}, 128'd0);

        // Single requester
        req0_valid = 1; req0_addr = 2; req0_data = 32'hAAAAFFFF;
        cycle();
        chk("single_we", {127'b0, RegWrite}, 128'd1);
        chk("single_reg", {126'b0, WriteReg}, 128'd2);
        req0_valid = 0;
        cycle();
        chk("single_read", {96'b0, rf[2]}, {96'b0, 32'hAAAAFFFF});

        // Idle: outputs hold, write enable low
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle_hold", {96'b0, WriteData}, {96'b0, 32'hAAAAFFFF});
        end

        // Contention from the first RUN cycle
        reset = 1; cycle();
        reset = 0;
        req0_valid = 1; req0_addr = 1; req0_data = 32'h11111111;
        req1_valid = 1; req1_addr = 3; req1_data = 32'h33333333;
        for (int i = 0; i < NREG; i++) cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("contention_gid", {127'b0, grant_id}, 128'(i % 2));
        end

        // Same address, pointer at 1
        req1_valid = 0;
        cycle();
        req0_addr = 0; req0_data = 32'h1;
        req1_valid = 1; req1_addr = 0; req1_data = 32'h2;
        cycle();
        chk("same_first", {127'b0, grant_id}, 128'd1);
        req1_valid = 0;
        cycle();
        chk("same_second", {127'b0, grant_id}, 128'd0);
        req0_valid = 0;
        cycle();
        chk("same_result", {96'b0, rf[0]}, 128'd1);

        // Random traffic honouring hold-until-ready
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || h0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr = ADDR_W'($urandom); req0_data = $urandom;
            end
            if (!req1_valid || h1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr = ADDR_W'($urandom); req1_data = $urandom;
            end
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            if (h0) req0_valid = 0;
            if (h1) req1_valid = 0;
            cycle();
        end
        chk("drained", {126'b0, req0_valid, req1_valid}, 128'd0);

        // Reset during a req1 handshake
        req0_valid = 0;
        req1_valid = 1; req1_addr = 2; req1_data = 32'hDEADBEEF;
        reset = 1;
        cycle();
        chk("rst_drop_we", {127'b0, RegWrite}, 128'd0);
        chk("rst_done_low", {127'b0, init_done}, 128'd0);
        reset = 0; req1_valid = 0;
        cycle();
        chk("rst_init_addr0", {126'b0, WriteReg}, 128'd0);
        for (int i = 0; i < 5; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
